voice_mix_sequencer: RTL

- Next-generation sample controller for the SID-like synth.
- Generalises the fixed 3-voice controller to NUM_VOICES voices, adds per-voice volume, per-voice mute, master volume, saturating signed mix and overrun flagging.
- On each sample tick it steps through the voices over a start/ready handshake with the shared time-multiplexed voice generator. It accumulates the scaled waveforms and emits one audio sample towards the output pins or a DAC.

---
 rtl/voice_mix_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/voice_mix_sequencer.sv
// Sample sequencer for the multi-voice synth.
// On each sample tick it walks the unmuted voices in ascending index order. For each voice
// it presents the voice config to a shared voice generator and pulses a start. It then waits
// for the ready/result, scales the result by the voice volume and accumulates it.
// After the last voice the sum is scaled by the master volume, shifted and saturated into
// one signed audio sample.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   sample_tick_i           one-cycle sample strobe
//   freq_i/pw_i/wave_sel_i  packed per-voice config, voice 0 in LSBs
//   vol_i, mute_i           packed per-voice volume, per-voice mute (1 = skip)
//   master_vol_i            master volume, latched at the tick
//   voice_ready_i/wave_i    voice generator result handshake
//   voice_start_o, voice_idx_o, voice_freq_o, voice_pw_o, voice_wave_o
//                           request to the voice generator, held until the next start
//   audio_o, audio_valid_o  signed mixed sample and its update pulse
//   overrun_o               pulse: a tick was dropped because a sequence was running
module voice_mix_sequencer #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned FREQ_W     = 16,
  parameter int unsigned PW_W       = 12,
  parameter int unsigned WAVE_W     = 10,
  parameter int unsigned VOL_W      = 4,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned SHIFT      = 2,
  localparam int unsigned IdxW      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sample_tick_i,
  input  logic [NUM_VOICES*FREQ_W-1:0] freq_i,
  input  logic [NUM_VOICES*PW_W-1:0]   pw_i,
  input  logic [NUM_VOICES*4-1:0]      wave_sel_i,
  input  logic [NUM_VOICES*VOL_W-1:0]  vol_i,
  input  logic [NUM_VOICES-1:0]        mute_i,
  input  logic [VOL_W-1:0]             master_vol_i,
  input  logic                         voice_ready_i,
  input  logic [WAVE_W-1:0]            voice_wave_i,
  output logic                         voice_start_o,
  output logic [IdxW-1:0]              voice_idx_o,
  output logic [FREQ_W-1:0]            voice_freq_o,
  output logic [PW_W-1:0]              voice_pw_o,
  output logic [3:0]                   voice_wave_o,
  output logic [OUT_W-1:0]             audio_o,
  output logic                         audio_valid_o,
  output logic                         overrun_o
);

  // Accumulator covers NUM_VOICES * 2^(WAVE_W-1) * (2^VOL_W-1) in both signs.
  localparam int unsigned AccW  = WAVE_W + VOL_W + $clog2(NUM_VOICES) + 1;
  localparam int unsigned ProdW = AccW + VOL_W + 1;
  localparam int unsigned SatW  = ((ProdW > OUT_W) ? ProdW : OUT_W) + 1;

  localparam logic signed [SatW-1:0] SatMax = {{(SatW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SatW-1:0] SatMin = {{(SatW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StStart, StWait, StNext, StScale, StOut} state_e;

  state_e                   state_q, state_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic signed [ProdW-1:0]  prod_q, prod_d;
  logic [NUM_VOICES-1:0]    mute_q, mute_d;
  logic [VOL_W-1:0]         master_q, master_d;
  logic [VOL_W-1:0]         vol_q, vol_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [FREQ_W-1:0]        freq_q, freq_d;
  logic [PW_W-1:0]          pw_q, pw_d;
  logic [3:0]               wsel_q, wsel_d;
  logic [OUT_W-1:0]         audio_q, audio_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;

  // Lowest unmuted voice at or above scan_from. In IDLE the live mute_i is scanned because
  // it is being latched in the same cycle.
  logic [NUM_VOICES-1:0] scan_mask;
  int unsigned           scan_from;
  logic                  scan_found;
  logic [IdxW-1:0]       scan_idx;

  always_comb begin
    scan_mask  = (state_q == StIdle) ? mute_i : mute_q;
    scan_from  = (state_q == StIdle) ? 32'd0 : 32'(idx_q) + 32'd1;
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!scan_found && (i >= scan_from) && !scan_mask[i]) begin
        scan_found = 1'b1;
        scan_idx   = IdxW'(i);
      end
    end
  end

  // Voice result re-centred to signed by MSB inversion, then scaled by the voice volume.
  logic signed [WAVE_W-1:0] wave_s;
  logic signed [AccW-1:0]   wave_x, vol_x, term;
  logic signed [ProdW-1:0]  acc_x, master_x, scaled;
  logic signed [SatW-1:0]   prod_x;

  always_comb begin
    wave_s   = {~voice_wave_i[WAVE_W-1], voice_wave_i[WAVE_W-2:0]};
    wave_x   = AccW'(wave_s);
    vol_x    = AccW'({1'b0, vol_q});
    term     = wave_x * vol_x;
    acc_x    = ProdW'(acc_q);
    master_x = ProdW'({1'b0, master_q});
    scaled   = (acc_x * master_x) >>> SHIFT;
    prod_x   = SatW'(prod_q);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    mute_d    = mute_q;
    master_d  = master_q;
    vol_d     = vol_q;
    idx_d     = idx_q;
    freq_d    = freq_q;
    pw_d      = pw_q;
    wsel_d    = wsel_q;
    audio_d   = audio_q;
    valid_d   = 1'b0;
    overrun_d = sample_tick_i && (state_q != StIdle);

    // Voice config is captured on entry to START so it is valid alongside the start pulse.
    if (((state_q == StIdle) && sample_tick_i) || (state_q == StNext)) begin
      if (scan_found) begin
        idx_d  = scan_idx;
        freq_d = freq_i[32'(scan_idx)*FREQ_W +: FREQ_W];
        pw_d   = pw_i[32'(scan_idx)*PW_W +: PW_W];
        wsel_d = wave_sel_i[32'(scan_idx)*4 +: 4];
        vol_d  = vol_i[32'(scan_idx)*VOL_W +: VOL_W];
      end
    end

    case (state_q)
      StIdle: begin
        if (sample_tick_i) begin
          acc_d    = '0;
          mute_d   = mute_i;
          master_d = master_vol_i;
          state_d  = scan_found ? StStart : StScale;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (voice_ready_i) begin
          acc_d   = acc_q + term;
          state_d = StNext;
        end
      end
      StNext:  state_d = scan_found ? StStart : StScale;
      StScale: begin
        prod_d  = scaled;
        state_d = StOut;
      end
      StOut: begin
        if (prod_x > SatMax) begin
          audio_d = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (prod_x < SatMin) begin
          audio_d = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
          audio_d = OUT_W'(prod_q);
        end
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      prod_q    <= '0;
      mute_q    <= '0;
      master_q  <= '0;
      vol_q     <= '0;
      idx_q     <= '0;
      freq_q    <= '0;
      pw_q      <= '0;
      wsel_q    <= '0;
      audio_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      mute_q    <= mute_d;
      master_q  <= master_d;
      vol_q     <= vol_d;
      idx_q     <= idx_d;
      freq_q    <= freq_d;
      pw_q      <= pw_d;
      wsel_q    <= wsel_d;
      audio_q   <= audio_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign voice_start_o = (state_q == StStart);
  assign voice_idx_o   = idx_q;
  assign voice_freq_o  = freq_q;
  assign voice_pw_o    = pw_q;
  assign voice_wave_o  = wsel_q;
  assign audio_o       = audio_q;
  assign audio_valid_o = valid_q;
  assign overrun_o     = overrun_q;

endmodule
